pc_unit: RTL and testbench

Parametrised program-counter unit for the RAT MCU. It combines the next-address mux, the PC register and an internal hardware return-address stack.
- Supports CALL/RET and interrupt entry/return without an external stack path.
- Sits between the control unit (load, increment and push strobes) and the program ROM address input.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_unit_return_stack.sv | 60 ++++++
 rtl/pc_unit.sv | 102 ++++++++++
 tb/tb_pc_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default sizing for the RAT MCU program-counter unit.
package pc_pkg;

    localparam int PC_ADDR_W_DEF   = 10;
    localparam int PC_RS_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        SEL_IMMED = 2'd0,
        SEL_STACK = 2'd1,
        SEL_INTR  = 2'd2,
        SEL_RESET = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_unit_return_stack.sv
// Hardware return-address LIFO; a simultaneous push and pop on a non-empty
// stack replaces the top entry in place.
module return_stack
    import pc_pkg::*;
#(
    parameter int W     = PC_ADDR_W_DEF,
    parameter int DEPTH = PC_RS_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             do_replace;
    logic             do_push;
    logic             do_pop;
    logic             write_en;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign top_idx = PTR_W'(level - LVL_W'(1));
    assign top     = mem[top_idx];

    // Push on an empty stack alongside a pop is a plain push (nothing to replace).
    assign do_replace = push && pop && !empty;
    assign do_push    = push && !full && !do_replace;
    assign do_pop     = pop && !empty && !push;
    assign write_en   = do_replace || do_push;
    assign wr_idx     = do_replace ? top_idx : level[PTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (do_push) begin
            level <= level + LVL_W'(1);
        end else if (do_pop) begin
            level <= level - LVL_W'(1);
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// RAT MCU program counter: next-address mux, PC register and internal
// return-address stack with sticky overflow/underflow flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W_DEF,
    parameter int                RS_DEPTH  = PC_RS_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] INTR_VEC  = '1,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       PC_LD,
    input  logic                       PC_INC,
    input  logic [1:0]                 PC_MUX_SEL,
    input  logic [ADDR_W-1:0]          FROM_IMMED,
    input  logic                       RS_PUSH,
    input  logic                       ERR_CLR,
    output logic [ADDR_W-1:0]          PC_COUNT,
    output logic                       RS_EMPTY,
    output logic                       RS_FULL,
    output logic [$clog2(RS_DEPTH):0]  RS_LEVEL,
    output logic                       RS_OVF,
    output logic                       RS_UNF
);

    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] mux_out;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] stack_top;
    logic              pop;
    logic              ovf_evt;
    logic              unf_evt;

    assign sel      = pc_sel_t'(PC_MUX_SEL);
    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign pop      = PC_LD && (sel == SEL_STACK);

    return_stack #(
        .W     (ADDR_W),
        .DEPTH (RS_DEPTH)
    ) u_stack (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (RS_PUSH),
        .pop   (pop),
        .wdata (pc_plus1),
        .top   (stack_top),
        .level (RS_LEVEL),
        .full  (RS_FULL),
        .empty (RS_EMPTY)
    );

    always_comb begin
        mux_out = RESET_VEC;
        case (sel)
            SEL_IMMED: mux_out = FROM_IMMED;
            SEL_STACK: mux_out = RS_EMPTY ? '0 : stack_top;
            SEL_INTR:  mux_out = INTR_VEC;
            SEL_RESET: mux_out = RESET_VEC;
            default:   mux_out = RESET_VEC;
        endcase
    end

    always_comb begin
        pc_next = pc_q;
        if (PC_LD) begin
            pc_next = mux_out;
        end else if (PC_INC) begin
            pc_next = pc_plus1;
        end
    end

    // A push alongside a pop never overflows: the top entry is replaced instead.
    assign ovf_evt = RS_PUSH && RS_FULL && !pop;
    assign unf_evt = pop && RS_EMPTY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q   <= RESET_VEC;
            RS_OVF <= 1'b0;
            RS_UNF <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (ovf_evt) begin
                RS_OVF <= 1'b1;
            end else if (ERR_CLR) begin
                RS_OVF <= 1'b0;
            end
            if (unf_evt) begin
                RS_UNF <= 1'b1;
            end else if (ERR_CLR) begin
                RS_UNF <= 1'b0;
            end
        end
    end

    assign PC_COUNT = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table plus multi-cycle sequences,
// with expectations queued at drive time and popped after each clock edge.
module tb_pc_unit;
    import pc_pkg::*;

    logic       CLK;
    logic       RST_N;
    logic       PC_LD;
    logic       PC_INC;
    logic [1:0] PC_MUX_SEL;
    logic [9:0] FROM_IMMED;
    logic       RS_PUSH;
    logic       ERR_CLR;
    logic [9:0] PC_COUNT;
    logic       RS_EMPTY;
    logic       RS_FULL;
    logic [3:0] RS_LEVEL;
    logic       RS_OVF;
    logic       RS_UNF;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       ld;
        logic       inc;
        logic [1:0] sel;
        logic [9:0] immed;
        logic       push;
        logic       clr;
        logic [9:0] pc;
        logic [3:0] lvl;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t sbq[$];
    vec_t tbl[25];

    pc_unit dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PC_LD      (PC_LD),
        .PC_INC     (PC_INC),
        .PC_MUX_SEL (PC_MUX_SEL),
        .FROM_IMMED (FROM_IMMED),
        .RS_PUSH    (RS_PUSH),
        .ERR_CLR    (ERR_CLR),
        .PC_COUNT   (PC_COUNT),
        .RS_EMPTY   (RS_EMPTY),
        .RS_FULL    (RS_FULL),
        .RS_LEVEL   (RS_LEVEL),
        .RS_OVF     (RS_OVF),
        .RS_UNF     (RS_UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic ld, logic inc, logic [1:0] sel, logic [9:0] immed,
                                logic push, logic clr, logic [9:0] pc, logic [3:0] lvl,
                                logic ovf, logic unf);
        vec_t v;
        v.ld = ld; v.inc = inc; v.sel = sel; v.immed = immed; v.push = push; v.clr = clr;
        v.pc = pc; v.lvl = lvl; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: actual=empty required=entry", tag);
        end else begin
            e = sbq.pop_front();
            cmp({tag, " pc"},    int'(PC_COUNT), int'(e.pc));
            cmp({tag, " level"}, int'(RS_LEVEL), int'(e.lvl));
            cmp({tag, " empty"}, int'(RS_EMPTY), int'(e.lvl == 4'd0));
            cmp({tag, " full"},  int'(RS_FULL),  int'(e.lvl == 4'd8));
            cmp({tag, " ovf"},   int'(RS_OVF),   int'(e.ovf));
            cmp({tag, " unf"},   int'(RS_UNF),   int'(e.unf));
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge CLK);
        PC_LD      = v.ld;
        PC_INC     = v.inc;
        PC_MUX_SEL = v.sel;
        FROM_IMMED = v.immed;
        RS_PUSH    = v.push;
        ERR_CLR    = v.clr;
        sbq.push_back(v);
        @(posedge CLK);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        RST_N = 1'b0; PC_LD = 0; PC_INC = 0; PC_MUX_SEL = 0;
        FROM_IMMED = 0; RS_PUSH = 0; ERR_CLR = 0;

        //           ld inc sel  immed    push clr  pc      lvl ovf unf
        tbl[0]  = mk(0, 1, 2'd0, 10'h000, 0, 0, 10'h001, 0, 0, 0);
        tbl[1]  = mk(0, 1, 2'd0, 10'h000, 0, 0, 10'h002, 0, 0, 0);
        tbl[2]  = mk(0, 1, 2'd0, 10'h000, 0, 0, 10'h003, 0, 0, 0);
        tbl[3]  = mk(1, 0, 2'd2, 10'h000, 0, 0, 10'h3FF, 0, 0, 0);
        tbl[4]  = mk(0, 1, 2'd0, 10'h000, 0, 0, 10'h000, 0, 0, 0);
        tbl[5]  = mk(1, 0, 2'd0, 10'h010, 0, 0, 10'h010, 0, 0, 0);
        tbl[6]  = mk(1, 0, 2'd0, 10'h120, 1, 0, 10'h120, 1, 0, 0);
        tbl[7]  = mk(1, 0, 2'd1, 10'h000, 0, 0, 10'h011, 0, 0, 0);
        tbl[8]  = mk(1, 0, 2'd0, 10'h040, 0, 0, 10'h040, 0, 0, 0);
        tbl[9]  = mk(1, 0, 2'd2, 10'h000, 1, 0, 10'h3FF, 1, 0, 0);
        tbl[10] = mk(1, 0, 2'd0, 10'h200, 1, 0, 10'h200, 2, 0, 0);
        tbl[11] = mk(1, 0, 2'd1, 10'h000, 0, 0, 10'h000, 1, 0, 0);
        tbl[12] = mk(1, 0, 2'd1, 10'h000, 0, 0, 10'h041, 0, 0, 0);
        tbl[13] = mk(1, 0, 2'd1, 10'h000, 0, 0, 10'h000, 0, 0, 1);
        tbl[14] = mk(0, 0, 2'd0, 10'h000, 0, 1, 10'h000, 0, 0, 0);
        tbl[15] = mk(1, 0, 2'd0, 10'h054, 0, 0, 10'h054, 0, 0, 0);
        tbl[16] = mk(0, 0, 2'd0, 10'h000, 1, 0, 10'h054, 1, 0, 0);
        tbl[17] = mk(1, 0, 2'd0, 10'h100, 0, 0, 10'h100, 1, 0, 0);
        tbl[18] = mk(1, 0, 2'd1, 10'h000, 1, 0, 10'h055, 1, 0, 0);
        tbl[19] = mk(1, 0, 2'd1, 10'h000, 0, 0, 10'h101, 0, 0, 0);
        tbl[20] = mk(1, 1, 2'd3, 10'h000, 0, 0, 10'h000, 0, 0, 0);
        tbl[21] = mk(1, 0, 2'd1, 10'h000, 1, 0, 10'h000, 1, 0, 1);
        tbl[22] = mk(1, 0, 2'd1, 10'h000, 0, 1, 10'h001, 0, 0, 0);
        tbl[23] = mk(1, 0, 2'd1, 10'h000, 0, 1, 10'h000, 0, 0, 1);
        tbl[24] = mk(0, 0, 2'd0, 10'h000, 0, 1, 10'h000, 0, 0, 0);

        #12;
        cmp("reset pc",    int'(PC_COUNT), 0);
        cmp("reset level", int'(RS_LEVEL), 0);
        cmp("reset empty", int'(RS_EMPTY), 1);
        cmp("reset full",  int'(RS_FULL),  0);
        cmp("reset ovf",   int'(RS_OVF),   0);
        cmp("reset unf",   int'(RS_UNF),   0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 25; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // Overflow: fill from PC 0x300, ninth push overflows.
        applyStimulus(mk(1, 0, 2'd0, 10'h300, 0, 0, 10'h300, 0, 0, 0), "ovf_pre");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(mk(0, 1, 2'd0, 10'h000, 1, 0, 10'h301 + 10'(i),
                             (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 0),
                          $sformatf("push%0d", i));
        end
        applyStimulus(mk(0, 0, 2'd0, 10'h000, 0, 1, 10'h309, 8, 0, 0), "ovf_clr");
        // Push with pop while full replaces top, no overflow.
        applyStimulus(mk(1, 0, 2'd1, 10'h000, 1, 0, 10'h308, 8, 0, 0), "full_swap");
        applyStimulus(mk(1, 0, 2'd1, 10'h000, 0, 0, 10'h30A, 7, 0, 0), "pop_swap");
        for (int j = 1; j < 8; j++) begin
            applyStimulus(mk(1, 0, 2'd1, 10'h000, 0, 0, 10'h308 - 10'(j), 4'(7 - j), 0, 0),
                          $sformatf("pop%0d", j));
        end

        // Build level 3 at PC 0x2AA, then reset between edges.
        applyStimulus(mk(1, 0, 2'd0, 10'h010, 1, 0, 10'h010, 1, 0, 0), "ar_push0");
        applyStimulus(mk(0, 0, 2'd0, 10'h000, 1, 0, 10'h010, 2, 0, 0), "ar_push1");
        applyStimulus(mk(1, 0, 2'd0, 10'h2AA, 1, 0, 10'h2AA, 3, 0, 0), "ar_push2");
        @(negedge CLK);
        PC_LD = 0; PC_INC = 1; RS_PUSH = 1;
        #2;
        RST_N = 1'b0;
        #1;
        cmp("async pc",    int'(PC_COUNT), 0);
        cmp("async level", int'(RS_LEVEL), 0);
        cmp("async empty", int'(RS_EMPTY), 1);
        @(posedge CLK);
        #1;
        cmp("held pc", int'(PC_COUNT), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        RS_PUSH = 0;
        sbq.push_back(mk(0, 1, 2'd0, 10'h000, 0, 0, 10'h001, 0, 0, 0));
        @(posedge CLK);
        #1;
        checkOutput("post_reset_inc");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
